wasm_stack_cpu: RTL and testbench

// WebAssembly-subset stack-machine core. Fetches bytecode through a byte-addressed read port
// (backed by a synchronous ROM), runs one function body from a start pc, and reports the value

---
 rtl/wasm_stack_cpu.sv | 248 ++++++++++++++++++++++++
 tb/tb_wasm_stack_cpu.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wasm_stack_cpu.sv
// rtl/wasm_stack_cpu.sv - WebAssembly-subset stack-machine core with LEB128 decode
module wasm_stack_cpu #(
  parameter int HAS_FPU     = 1,
  parameter int USE_64B     = 1,
  parameter int MEM_DEPTH   = 8,
  parameter int STACK_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [MEM_DEPTH:0]   pc,
  input  logic [STACK_DEPTH:0] index,
  output logic [63:0]          result,
  output logic [1:0]           result_type,
  output logic                 result_empty,
  output logic [3:0]           trap,
  output logic [MEM_DEPTH:0]   mem_addr,
  output logic [3:0]           mem_extra,
  input  logic [127:0]         mem_data,
  input  logic                 mem_error
);

  localparam int NENT = 2 ** (STACK_DEPTH + 1);
  localparam int SW   = STACK_DEPTH + 2;
  localparam logic [SW-1:0] SP_MAX = SW'(NENT);

  localparam logic [1:0] T_I32 = 2'd0;
  localparam logic [1:0] T_I64 = 2'd1;
  localparam logic [1:0] T_F32 = 2'd2;
  localparam logic [1:0] T_F64 = 2'd3;

  localparam logic [3:0] TR_NONE  = 4'd0;
  localparam logic [3:0] TR_ENDED = 4'd1;
  localparam logic [3:0] TR_UNREA = 4'd2;
  localparam logic [3:0] TR_ILL   = 4'd3;
  localparam logic [3:0] TR_STACK = 4'd4;
  localparam logic [3:0] TR_TYPE  = 4'd5;
  localparam logic [3:0] TR_MEM   = 4'd6;

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;

  state_t state, state_next;

  logic [MEM_DEPTH:0]   pc_q;
  logic [SW-1:0]        sp_q;
  logic [STACK_DEPTH:0] idx_q;
  logic [7:0]           op_q;
  logic [63:0]          imm_q;
  logic [3:0]           len_q;
  logic                 leb_bad_q;
  logic [3:0]           trap_q;
  logic [63:0]          result_q;
  logic [1:0]           rtype_q;
  logic [65:0]          stack [NENT];

  // Decode-side signals
  logic [69:0] leb_acc;
  logic [3:0]  leb_len;
  logic        leb_done;
  logic        leb_sign;
  logic [63:0] dec_imm;
  logic [3:0]  dec_len;
  logic        dec_bad;

  // Execute-side signals
  logic [STACK_DEPTH:0] tos_i, nos_i, new_top;
  logic [65:0]          tos, nos, top_next;
  logic                 empty, full, two_ok, loc_bad;
  logic [3:0]           ex_trap;
  logic                 ex_we;
  logic [STACK_DEPTH:0] ex_wa;
  logic [65:0]          ex_wd;
  logic [SW-1:0]        ex_sp;
  logic [31:0]          sum32;
  logic [63:0]          sum64;

  logic unused_bits;
  assign unused_bits = ^{mem_data[127:88], leb_acc[69:64]};

  assign mem_addr     = pc_q;
  assign mem_extra    = (state == S_FETCH && reset) ? 4'd15 : 4'd0;
  assign result       = result_q;
  assign result_type  = rtype_q;
  assign trap         = trap_q;
  assign result_empty = (sp_q == {1'b0, idx_q});

  // LEB128 operand and raw float immediates from the fetched bytes
  always_comb begin
    leb_acc  = '0;
    leb_len  = 4'd0;
    leb_done = 1'b0;
    leb_sign = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (!leb_done) begin
        leb_acc[7*(k-1) +: 7] = mem_data[8*k +: 7];
        if (!mem_data[8*k+7]) begin
          leb_done = 1'b1;
          leb_len  = 4'(k);
          leb_sign = mem_data[8*k+6];
        end
      end
    end
    if (leb_sign) leb_acc = leb_acc | ~((70'd1 << (7 * leb_len)) - 70'd1);
    dec_imm = leb_acc[63:0];
    dec_len = leb_len;
    dec_bad = 1'b0;
    case (mem_data[7:0])
      8'h41, 8'h42, 8'h20, 8'h21, 8'h22: dec_bad = !leb_done;
      8'h43: begin dec_imm = {32'd0, mem_data[39:8]}; dec_len = 4'd4; end
      8'h44: begin dec_imm = mem_data[71:8];          dec_len = 4'd8; end
      default: dec_len = 4'd0;
    endcase
  end

  // Stack effect and trap decision of the latched instruction
  always_comb begin
    tos_i   = sp_q[STACK_DEPTH:0] - 1'b1;
    nos_i   = sp_q[STACK_DEPTH:0] - 2'd2;
    tos     = stack[tos_i];
    nos     = stack[nos_i];
    empty   = (sp_q == {1'b0, idx_q});
    full    = (sp_q == SP_MAX);
    two_ok  = ((sp_q - {1'b0, idx_q}) >= SW'(2));
    loc_bad = (imm_q >= 64'(idx_q));
    sum32   = tos[31:0] + nos[31:0];
    sum64   = tos[63:0] + nos[63:0];
    ex_trap = TR_NONE;
    ex_we   = 1'b0;
    ex_wa   = sp_q[STACK_DEPTH:0];
    ex_wd   = '0;
    ex_sp   = sp_q;
    case (op_q)
      8'h00: ex_trap = TR_UNREA;
      8'h01: ;
      8'h0B: ex_trap = TR_ENDED;
      8'h1A: if (empty) ex_trap = TR_STACK; else ex_sp = sp_q - 1'b1;
      8'h41, 8'h42: begin
        if (leb_bad_q || (op_q == 8'h42 && USE_64B == 0)) ex_trap = TR_ILL;
        else if (full) ex_trap = TR_STACK;
        else begin
          ex_we = 1'b1;
          ex_wd = (op_q == 8'h41) ? {T_I32, 32'd0, imm_q[31:0]} : {T_I64, imm_q};
          ex_sp = sp_q + 1'b1;
        end
      end
      8'h43, 8'h44: begin
        if (HAS_FPU == 0) ex_trap = TR_ILL;
        else if (full) ex_trap = TR_STACK;
        else begin
          ex_we = 1'b1;
          ex_wd = {(op_q == 8'h43) ? T_F32 : T_F64, imm_q};
          ex_sp = sp_q + 1'b1;
        end
      end
      8'h20: begin
        if (leb_bad_q) ex_trap = TR_ILL;
        else if (loc_bad || full) ex_trap = TR_STACK;
        else begin
          ex_we = 1'b1;
          ex_wd = stack[imm_q[STACK_DEPTH:0]];
          ex_sp = sp_q + 1'b1;
        end
      end
      8'h21, 8'h22: begin
        if (leb_bad_q) ex_trap = TR_ILL;
        else if (loc_bad || empty) ex_trap = TR_STACK;
        else begin
          ex_we = 1'b1;
          ex_wa = imm_q[STACK_DEPTH:0];
          ex_wd = tos;
          if (op_q == 8'h21) ex_sp = sp_q - 1'b1;
        end
      end
      8'h6A, 8'h7C: begin
        if (op_q == 8'h7C && USE_64B == 0) ex_trap = TR_ILL;
        else if (!two_ok) ex_trap = TR_STACK;
        else if (op_q == 8'h6A && (tos[65:64] != T_I32 || nos[65:64] != T_I32)) ex_trap = TR_TYPE;
        else if (op_q == 8'h7C && (tos[65:64] != T_I64 || nos[65:64] != T_I64)) ex_trap = TR_TYPE;
        else begin
          ex_we = 1'b1;
          ex_wa = nos_i;
          ex_wd = (op_q == 8'h6A) ? {T_I32, 32'd0, sum32} : {T_I64, sum64};
          ex_sp = sp_q - 1'b1;
        end
      end
      default: ex_trap = TR_ILL;
    endcase
    new_top  = ex_sp[STACK_DEPTH:0] - 1'b1;
    top_next = (ex_we && ex_wa == new_top) ? ex_wd : stack[new_top];
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_next;
  end

  // FSM next state: fetch, decode, execute, stop on any trap
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: state_next = mem_error ? S_HALT : S_EXEC;
      S_EXEC:   state_next = (ex_trap != TR_NONE) ? S_HALT : S_FETCH;
      default:  state_next = S_HALT;
    endcase
  end

  // Datapath: frame setup on reset, decode latch, stack and pc update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q      <= pc;
      sp_q      <= {1'b0, index};
      idx_q     <= index;
      op_q      <= 8'h01;
      imm_q     <= '0;
      len_q     <= '0;
      leb_bad_q <= 1'b0;
      trap_q    <= TR_NONE;
      result_q  <= '0;
      rtype_q   <= T_I32;
      for (int i = 0; i < NENT; i++) stack[i] <= {T_I64, 64'd0};
    end else begin
      case (state)
        S_DECODE: begin
          if (mem_error) trap_q <= TR_MEM;
          else begin
            op_q      <= mem_data[7:0];
            imm_q     <= dec_imm;
            len_q     <= dec_len;
            leb_bad_q <= dec_bad;
          end
        end
        S_EXEC: begin
          if (ex_trap != TR_NONE) trap_q <= ex_trap;
          else begin
            if (ex_we) stack[ex_wa] <= ex_wd;
            sp_q     <= ex_sp;
            pc_q     <= pc_q + (MEM_DEPTH+1)'(len_q) + (MEM_DEPTH+1)'(1);
            result_q <= top_next[63:0];
            rtype_q  <= top_next[65:64];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wasm_stack_cpu.sv
// tb/tb_wasm_stack_cpu.sv - self-checking bench for wasm_stack_cpu with interpreter model
module tb_wasm_stack_cpu;
  localparam int ROM_SIZE = 256;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [8:0]   pc = '0;
  logic [8:0]   index = '0;
  logic [63:0]  result;
  logic [1:0]   result_type;
  logic         result_empty;
  logic [3:0]   trap;
  logic [8:0]   mem_addr;
  logic [3:0]   mem_extra;
  logic [127:0] mem_data = '0;
  logic         mem_error = 1'b0;

  logic [7:0] rom [0:ROM_SIZE-1];
  logic [7:0] prog [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wasm_stack_cpu dut (
    .clk(clk), .reset(reset), .pc(pc), .index(index),
    .result(result), .result_type(result_type), .result_empty(result_empty), .trap(trap),
    .mem_addr(mem_addr), .mem_extra(mem_extra), .mem_data(mem_data), .mem_error(mem_error)
  );

  // Synchronous ROM: 16 bytes from the address, error if the request runs past the end
  always @(posedge clk) begin
    for (int k = 0; k < 16; k++)
      mem_data[8*k +: 8] <= (int'(mem_addr) + k < ROM_SIZE) ? rom[8'(int'(mem_addr) + k)] : 8'h00;
    mem_error <= (int'(mem_addr) + int'(mem_extra)) >= ROM_SIZE;
  end

  task automatic load_prog(input int start);
    for (int i = 0; i < ROM_SIZE; i++) rom[i] = 8'h00;
    for (int i = 0; i < prog.size(); i++)
      if (start + i < ROM_SIZE) rom[8'(start + i)] = prog[i];
  endtask

  task automatic run_prog(input int start, input int nloc, output int cyc);
    @(negedge clk);
    pc = 9'(start); index = 9'(nloc); reset = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    while (trap == 4'd0 && cyc < 3000) begin
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic emit_sleb(input logic [63:0] v);
    logic [63:0] x; logic [7:0] b; bit more;
    x = v; more = 1'b1;
    while (more) begin
      b = {1'b0, x[6:0]};
      x = $signed(x) >>> 7;
      if ((x == 64'd0 && !b[6]) || (x == '1 && b[6])) more = 1'b0;
      else b[7] = 1'b1;
      prog.push_back(b);
    end
  endtask

  task automatic read_leb(input int at, output logic [63:0] v, output int len, output bit ok);
    logic [7:0] b;
    v = '0; len = 0; ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!ok) begin
        b = rom[8'(at + i)];
        v = v | (64'(b[6:0]) << (7 * i));
        if (!b[7]) begin
          ok = 1'b1; len = i + 1;
          if (b[6] && 7 * (i + 1) < 64) v = v | (~64'd0 << (7 * (i + 1)));
        end
      end
    end
  endtask

  // Instruction-level interpreter: locals array plus operand queue
  task automatic model_run(input int start, input int nloc, output int m_trap,
                           output logic [65:0] m_top, output bit m_empty);
    logic [65:0] locs [0:511];
    logic [65:0] stk [$];
    logic [65:0] a, b;
    logic [63:0] v, raw;
    logic [31:0] s32;
    logic [7:0] op;
    int p, len, steps; bit ok;
    for (int i = 0; i < 512; i++) locs[i] = {2'd1, 64'd0};
    p = start; m_trap = 0; steps = 0;
    while (m_trap == 0 && steps < 5000) begin
      steps++;
      if (p + 15 >= ROM_SIZE) m_trap = 6;
      else begin
        op = rom[8'(p)];
        read_leb(p + 1, v, len, ok);
        case (op)
          8'h00: m_trap = 2;
          8'h01: p += 1;
          8'h0B: m_trap = 1;
          8'h1A: if (stk.size() == 0) m_trap = 4; else begin a = stk.pop_back(); p += 1; end
          8'h41, 8'h42: begin
            if (!ok) m_trap = 3;
            else if (nloc + stk.size() >= 512) m_trap = 4;
            else begin
              stk.push_back(op == 8'h41 ? {2'd0, 32'd0, v[31:0]} : {2'd1, v});
              p += 1 + len;
            end
          end
          8'h43, 8'h44: begin
            raw = '0;
            for (int i = 0; i < 8; i++)
              if (op == 8'h44 || i < 4) raw[8*i +: 8] = rom[8'(p + 1 + i)];
            if (nloc + stk.size() >= 512) m_trap = 4;
            else begin
              stk.push_back({(op == 8'h43) ? 2'd2 : 2'd3, raw});
              p += (op == 8'h43) ? 5 : 9;
            end
          end
          8'h20: begin
            if (!ok) m_trap = 3;
            else if (v >= 64'(nloc) || nloc + stk.size() >= 512) m_trap = 4;
            else begin stk.push_back(locs[v[8:0]]); p += 1 + len; end
          end
          8'h21, 8'h22: begin
            if (!ok) m_trap = 3;
            else if (v >= 64'(nloc) || stk.size() == 0) m_trap = 4;
            else begin
              locs[v[8:0]] = stk[$];
              if (op == 8'h21) a = stk.pop_back();
              p += 1 + len;
            end
          end
          8'h6A, 8'h7C: begin
            if (stk.size() < 2) m_trap = 4;
            else if (op == 8'h6A && (stk[$][65:64] != 2'd0 || stk[$-1][65:64] != 2'd0)) m_trap = 5;
            else if (op == 8'h7C && (stk[$][65:64] != 2'd1 || stk[$-1][65:64] != 2'd1)) m_trap = 5;
            else begin
              a = stk.pop_back(); b = stk.pop_back();
              s32 = a[31:0] + b[31:0];
              stk.push_back(op == 8'h6A ? {2'd0, 32'd0, s32} : {2'd1, a[63:0] + b[63:0]});
              p += 1;
            end
          end
          default: m_trap = 3;
        endcase
      end
    end
    m_empty = (stk.size() == 0);
    m_top = m_empty ? 66'd0 : stk[$];
  endtask

  task automatic test_reset;
    pc = 9'd17; index = 9'd3; reset = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (trap !== 4'd0) begin errors++; $display("FAIL reset_trap got %0d want 0", trap); end
    checks++; if (result !== 64'd0) begin errors++; $display("FAIL reset_result got %0h want 0", result); end
    checks++; if (result_type !== 2'd0) begin errors++; $display("FAIL reset_type got %0d want 0", result_type); end
    checks++; if (result_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b want 1", result_empty); end
    checks++; if (mem_addr !== 9'd17) begin errors++; $display("FAIL reset_addr got %0d want 17", mem_addr); end
    checks++; if (mem_extra !== 4'd0) begin errors++; $display("FAIL reset_extra got %0d want 0", mem_extra); end
  endtask

  task automatic test_timing;
    int cyc;
    prog = '{8'h42, 8'h02, 8'h22, 8'h00, 8'h0B};
    load_prog(17);
    run_prog(17, 1, cyc);
    checks++; if (trap !== 4'd1) begin errors++; $display("FAIL tee_trap got %0d want 1", trap); end
    checks++; if (cyc !== 9) begin errors++; $display("FAIL tee_cycles got %0d want 9", cyc); end
    checks++; if (result !== 64'd2 || result_type !== 2'd1) begin
      errors++; $display("FAIL tee_result got %0h/%0d want 2/1", result, result_type); end
    checks++; if (result_empty !== 1'b0) begin errors++; $display("FAIL tee_empty got %0b want 0", result_empty); end
  endtask

  task automatic test_arith;
    int cyc;
    logic [63:0] want_v [4];
    logic [1:0]  want_t [4];
    want_v = '{64'd2, 64'd0, 64'd5, 64'h3FF0000000000000};
    want_t = '{2'd0, 2'd1, 2'd0, 2'd3};
    for (int t = 0; t < 4; t++) begin
      case (t)
        0: prog = '{8'h41, 8'h7F, 8'h41, 8'h03, 8'h6A, 8'h0B};
        1: prog = '{8'h42, 8'h7F, 8'h42, 8'h01, 8'h7C, 8'h0B};
        2: prog = '{8'h41, 8'h05, 8'h21, 8'h00, 8'h20, 8'h00, 8'h0B};
        default: prog = '{8'h44, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF0, 8'h3F, 8'h0B};
      endcase
      load_prog(4);
      run_prog(4, 1, cyc);
      checks++;
      if (trap !== 4'd1 || result !== want_v[t] || result_type !== want_t[t] || result_empty !== 1'b0) begin
        errors++;
        $display("FAIL arith_%0d got trap=%0d res=%0h type=%0d empty=%0b want trap=1 res=%0h type=%0d empty=0",
                 t, trap, result, result_type, result_empty, want_v[t], want_t[t]);
      end
    end
  endtask

  task automatic test_traps;
    int cyc, start, nloc;
    logic [3:0] want_trap [8];
    bit         want_empty [8];
    logic [63:0] want_v [8];
    want_trap  = '{4'd4, 4'd2, 4'd3, 4'd5, 4'd3, 4'd4, 4'd6, 4'd4};
    want_empty = '{1, 1, 1, 0, 1, 1, 1, 0};
    want_v     = '{64'd0, 64'd0, 64'd0, 64'd1, 64'd0, 64'd0, 64'd0, 64'd1};
    for (int t = 0; t < 8; t++) begin
      start = 10; nloc = 0;
      case (t)
        0: prog = '{8'h1A};
        1: prog = '{8'h00};
        2: prog = '{8'hFF};
        3: prog = '{8'h41, 8'h01, 8'h42, 8'h01, 8'h7C};
        4: begin prog = '{8'h41}; for (int i = 0; i < 11; i++) prog.push_back(8'h80); prog.push_back(8'h00); end
        5: begin prog = '{8'h20, 8'h01, 8'h0B}; nloc = 1; end
        6: begin prog = '{8'h01}; start = 300; end
        default: begin prog = '{8'h41, 8'h01, 8'h41, 8'h02, 8'h0B}; nloc = 511; end
      endcase
      load_prog(start);
      run_prog(start, nloc, cyc);
      checks++;
      if (trap !== want_trap[t] || result_empty !== want_empty[t]) begin
        errors++;
        $display("FAIL trap_%0d got trap=%0d empty=%0b want trap=%0d empty=%0b",
                 t, trap, result_empty, want_trap[t], want_empty[t]);
      end
      if (!want_empty[t]) begin
        checks++;
        if (result !== want_v[t]) begin
          errors++; $display("FAIL trap_res_%0d got %0h want %0h", t, result, want_v[t]);
        end
      end
    end
  endtask

  task automatic test_reset_abort;
    prog = '{8'h41, 8'h05};
    for (int i = 0; i < 30; i++) prog.push_back(8'h01);
    prog.push_back(8'h0B);
    load_prog(0);
    @(negedge clk); pc = 9'd0; index = 9'd0; reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (result_empty !== 1'b0 || result !== 64'd5) begin
      errors++; $display("FAIL abort_pre got empty=%0b res=%0h want 0/5", result_empty, result); end
    reset = 1'b0; #1;
    checks++; if (result_empty !== 1'b1 || trap !== 4'd0 || result !== 64'd0) begin
      errors++; $display("FAIL abort_post got empty=%0b trap=%0d res=%0h want 1/0/0", result_empty, trap, result); end
  endtask

  task automatic gen_random(input int nloc);
    int n, sel;
    logic [31:0] r;
    prog.delete();
    n = $urandom_range(1, 12);
    for (int i = 0; i < n; i++) begin
      sel = $urandom_range(0, 12);
      case (sel)
        0, 1, 2: begin
          prog.push_back(8'h41);
          r = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 200)) - 32'd100;
          emit_sleb({{32{r[31]}}, r});
        end
        3, 4: begin prog.push_back(8'h42); emit_sleb({$urandom, $urandom}); end
        5: begin prog.push_back(8'h43); for (int k = 0; k < 4; k++) prog.push_back(8'($urandom)); end
        6: begin prog.push_back(8'h44); for (int k = 0; k < 8; k++) prog.push_back(8'($urandom)); end
        7: begin prog.push_back(8'h20); emit_sleb(64'($urandom_range(0, nloc))); end
        8: begin prog.push_back(8'h21); emit_sleb(64'($urandom_range(0, nloc))); end
        9: begin prog.push_back(8'h22); emit_sleb(64'($urandom_range(0, nloc))); end
        10: prog.push_back(8'h6A);
        11: prog.push_back(8'h7C);
        default: prog.push_back(($urandom_range(0, 1) == 1) ? 8'h1A : 8'h01);
      endcase
    end
    prog.push_back(8'h0B);
  endtask

  task automatic test_random;
    int cyc, start, nloc, m_trap;
    logic [65:0] m_top;
    bit m_empty;
    for (int r = 0; r < 60; r++) begin
      nloc = $urandom_range(0, 3);
      start = $urandom_range(0, 60);
      gen_random(nloc);
      load_prog(start);
      model_run(start, nloc, m_trap, m_top, m_empty);
      run_prog(start, nloc, cyc);
      checks++;
      if (trap !== 4'(m_trap) || result_empty !== m_empty) begin
        errors++;
        $display("FAIL rand_%0d got trap=%0d empty=%0b want trap=%0d empty=%0b",
                 r, trap, result_empty, m_trap, m_empty);
      end
      if (!m_empty) begin
        checks++;
        if (result !== m_top[63:0] || result_type !== m_top[65:64]) begin
          errors++;
          $display("FAIL rand_res_%0d got %0h/%0d want %0h/%0d", r, result, result_type, m_top[63:0], m_top[65:64]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < ROM_SIZE; i++) rom[i] = 8'h00;
    test_reset;
    test_timing;
    test_arith;
    test_traps;
    test_reset_abort;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
